// File: rtl/booth_mul_sched.sv
// Round-robin scheduler for two requesters sharing one radix-2 Booth multiplier.
// Optional serial product frame on tx when BOOTH_SCHED_SERIAL_TX_EN is defined.
module booth_mul_sched #(
  parameter int WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  output logic                 res_valid,
  output logic                 res_id,
  output logic [2*WIDTH-1:0]   res_product,
  output logic                 busy,
  output logic                 tx
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nx;
  logic               last_id, sel, accept, tx_idle;
  logic [WIDTH:0]     acc, acc_sum, acc_sh, m_ext;
  logic [WIDTH-1:0]   q_reg, m_reg, q_sh, a_sel, b_sel;
  logic               q_minus, q_minus_sh;
  logic [CW-1:0]      cnt;

  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) sel = ~last_id;
    else if (req1_valid)          sel = 1'b1;
  end

  // RST_N term keeps both readies low while reset is asserted
  assign req0_ready = RST_N && (state == IDLE) && tx_idle && !sel && req0_valid;
  assign req1_ready = RST_N && (state == IDLE) && tx_idle &&  sel && req1_valid;
  assign accept     = req0_ready || req1_ready;
  assign a_sel      = sel ? req1_a : req0_a;
  assign b_sel      = sel ? req1_b : req0_b;

  // One Booth step: add/subtract M into the WIDTH+1 bit accumulator, then shift
  always_comb begin
    m_ext = {m_reg[WIDTH-1], m_reg};
    case ({q_reg[0], q_minus})
      2'b01:   acc_sum = acc + m_ext;
      2'b10:   acc_sum = acc - m_ext;
      default: acc_sum = acc;
    endcase
    {acc_sh, q_sh, q_minus_sh} = {acc_sum[WIDTH], acc_sum, q_reg};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (cnt == CW'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc         <= '0;
      q_reg       <= '0;
      m_reg       <= '0;
      q_minus     <= 1'b0;
      cnt         <= '0;
      last_id     <= 1'b1;
      res_id      <= 1'b0;
      res_valid   <= 1'b0;
      res_product <= '0;
    end else begin
      res_valid <= 1'b0;
      if (accept) begin
        acc     <= '0;
        q_reg   <= a_sel;
        m_reg   <= b_sel;
        q_minus <= 1'b0;
        cnt     <= CW'(WIDTH);
        res_id  <= sel;
        last_id <= sel;
      end else if (state == RUN) begin
        acc     <= acc_sh;
        q_reg   <= q_sh;
        q_minus <= q_minus_sh;
        cnt     <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          res_valid   <= 1'b1;
          res_product <= {acc_sh[WIDTH-1:0], q_sh};
        end
      end
    end
  end

`ifdef BOOTH_SCHED_SERIAL_TX_EN
  localparam int FW  = 2 * WIDTH + 2;
  localparam int FCW = $clog2(FW + 1);

  logic [FW-1:0]  frame_sh;
  logic [FCW-1:0] frame_cnt;

  // Frame is {stop, product, start}, shifted out LSB first
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      frame_sh  <= '1;
      frame_cnt <= '0;
    end else if (state == DONE) begin
      frame_sh  <= {1'b1, res_product, 1'b0};
      frame_cnt <= FCW'(FW);
    end else if (frame_cnt != '0) begin
      frame_sh  <= {1'b1, frame_sh[FW-1:1]};
      frame_cnt <= frame_cnt - FCW'(1);
    end
  end

  assign tx_idle = (frame_cnt == '0);
  assign tx      = tx_idle ? 1'b1 : frame_sh[0];
`else
  assign tx_idle = 1'b1;
  assign tx      = 1'b1;
`endif

  assign busy = (state != IDLE) || !tx_idle;

endmodule
